// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the pipeline-control state type.
package y86_pkg;

  localparam int unsigned ICODE_W = 4;
  localparam int unsigned STAT_W  = 2;
  localparam int unsigned REG_W   = 4;

  localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'd5;
  localparam logic [ICODE_W-1:0] I_OPQ    = 4'd6;
  localparam logic [ICODE_W-1:0] I_JXX    = 4'd7;
  localparam logic [ICODE_W-1:0] I_RET    = 4'd9;
  localparam logic [ICODE_W-1:0] I_POPQ   = 4'd11;

  localparam logic [STAT_W-1:0] STAT_AOK = 2'd0;
  localparam logic [STAT_W-1:0] STAT_HLT = 2'd1;
  localparam logic [STAT_W-1:0] STAT_ADR = 2'd2;
  localparam logic [STAT_W-1:0] STAT_INS = 2'd3;

  localparam logic [REG_W-1:0] RNONE = 4'd15;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational hazard terms: load-use, mispredict and ret hazard.
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] d_icode_i,
  input  logic [3:0] d_srca_i,
  input  logic [3:0] d_srcb_i,
  input  logic [3:0] e_icode_i,
  input  logic [3:0] e_dstm_i,
  input  logic       e_cnd_i,
  input  logic       ret_pend_i,
  output logic       lu_o,
  output logic       mp_o,
  output logic       rh_o
);

  logic e_is_load;

  assign e_is_load = (e_icode_i == I_MRMOVQ) || (e_icode_i == I_POPQ);
  assign lu_o      = e_is_load && (e_dstm_i != RNONE) &&
                     ((e_dstm_i == d_srca_i) || (e_dstm_i == d_srcb_i));
  assign mp_o      = (e_icode_i == I_JXX) && !e_cnd_i;
  assign rh_o      = (d_icode_i == I_RET) || ret_pend_i;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline stall/bubble sequencer with ret tracking and exception FSM.
// Optional performance counters are enabled with `PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned RET_GAP = 2
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W  = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       set_cc,
  output logic       halted,
  output logic [1:0] proc_stat
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cyc_cnt,
  output logic [PERF_W-1:0] lu_cnt,
  output logic [PERF_W-1:0] mp_cnt,
  output logic [PERF_W-1:0] ret_cnt_ev
`endif
);

  localparam int unsigned RET_W = 2;

  ctrl_state_t       state_q, state_d;
  logic [RET_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [STAT_W-1:0] proc_stat_q, proc_stat_d;
  logic              lu, mp, rh, exc_m, exc_w, ret_load;

  hazard_detect u_hazard (
    .d_icode_i  (D_icode),
    .d_srca_i   (d_srcA),
    .d_srcb_i   (d_srcB),
    .e_icode_i  (E_icode),
    .e_dstm_i   (E_dstM),
    .e_cnd_i    (e_Cnd),
    .ret_pend_i (ret_cnt_q != '0),
    .lu_o       (lu),
    .mp_o       (mp),
    .rh_o       (rh)
  );

  assign exc_m = (m_stat != STAT_AOK);
  assign exc_w = (W_stat != STAT_AOK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_cnt_q   <= '0;
      proc_stat_q <= STAT_AOK;
    end else begin
      state_q     <= state_d;
      ret_cnt_q   <= ret_cnt_d;
      proc_stat_q <= proc_stat_d;
    end
  end

  // Next state, ret countdown and per-stage controls.
  always_comb begin
    state_d     = state_q;
    ret_cnt_d   = ret_cnt_q;
    proc_stat_d = proc_stat_q;
    ret_load    = 1'b0;
    F_stall     = 1'b0;
    D_stall     = 1'b0;
    D_bubble    = 1'b0;
    E_bubble    = 1'b0;
    M_bubble    = 1'b0;
    W_stall     = 1'b0;
    set_cc      = 1'b0;

    unique case (state_q)
      RUN: begin
        if (exc_w) begin
          state_d     = HALTED;
          proc_stat_d = W_stat;
        end else if (exc_m) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (exc_w) begin
          state_d     = HALTED;
          proc_stat_d = W_stat;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase

    // A squashed or load-use-held ret in D must not start the countdown.
    if ((state_q == RUN) && (state_d == DRAIN)) begin
      ret_cnt_d = '0;
    end else if ((state_q == RUN) && (D_icode == I_RET) && !lu && !mp) begin
      ret_cnt_d = RET_W'(RET_GAP);
      ret_load  = 1'b1;
    end else if (ret_cnt_q != '0) begin
      ret_cnt_d = ret_cnt_q - RET_W'(1);
    end

    if (state_q == HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end else begin
      F_stall  = lu | rh;
      D_stall  = lu;
      D_bubble = mp | (rh & !lu);
      E_bubble = mp | lu;
      M_bubble = exc_m | exc_w | (state_q == DRAIN);
      W_stall  = exc_w;
      set_cc   = (E_icode == I_OPQ) && !exc_m && !exc_w && (state_q == RUN);
    end

    if (!rst_n) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      set_cc   = 1'b0;
    end
  end

  assign halted    = (state_q == HALTED);
  assign proc_stat = proc_stat_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] cyc_q, lu_q, mp_q, ret_ev_q;

  // Event counters, frozen once halted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q    <= '0;
      lu_q     <= '0;
      mp_q     <= '0;
      ret_ev_q <= '0;
    end else if (state_q != HALTED) begin
      cyc_q <= cyc_q + PERF_W'(1);
      if (lu)       lu_q     <= lu_q + PERF_W'(1);
      if (mp)       mp_q     <= mp_q + PERF_W'(1);
      if (ret_load) ret_ev_q <= ret_ev_q + PERF_W'(1);
    end
  end

  assign cyc_cnt    = cyc_q;
  assign lu_cnt     = lu_q;
  assign mp_cnt     = mp_q;
  assign ret_cnt_ev = ret_ev_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expectations, a monitor checks them.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] D_icode = 4'd1, d_srcA = 4'd15, d_srcB = 4'd15;
  logic [3:0] E_icode = 4'd1, E_dstM = 4'd15;
  logic       e_Cnd = 1'b1;
  logic [1:0] m_stat = 2'd0, W_stat = 2'd0;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [1:0] proc_stat;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt_ev;
`endif

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
    .proc_stat(proc_stat)
`ifdef PIPE_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt_ev(ret_cnt_ev)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] ctl;
    logic       cyc_chk;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted, proc_stat}
  function automatic logic [9:0] mk(input bit f, input bit ds, input bit db, input bit eb,
                                    input bit mb, input bit ws, input bit cc, input bit h,
                                    input logic [1:0] ps);
    return {f, ds, db, eb, mb, ws, cc, h, ps};
  endfunction

  task automatic step(input string name, input logic rst, input logic [3:0] di,
                      input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] ei,
                      input logic [3:0] ed, input logic cnd, input logic [1:0] ms,
                      input logic [1:0] ws, input logic [9:0] ctl,
                      input bit cchk = 1'b0, input int cyc = 0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; D_icode = di; d_srcA = sa; d_srcB = sb;
    E_icode = ei; E_dstM = ed; e_Cnd = cnd; m_stat = ms; W_stat = ws;
    e.name = name; e.ctl = ctl; e.cyc_chk = cchk; e.cyc = cyc;
    q.push_back(e);
  endtask

  // Monitor: compares the oldest expectation mid-cycle.
  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted, proc_stat};
        total++;
        if (act === e.ctl) passed++;
        else $display("FAIL %s: ctl got %b want %b", e.name, act, e.ctl);
`ifdef PIPE_CTRL_PERF_EN
        if (e.cyc_chk) begin
          total++;
          if (cyc_cnt === 32'(e.cyc)) passed++;
          else $display("FAIL %s cyc_cnt: got %0d want %0d", e.name, cyc_cnt, e.cyc);
        end
`endif
      end
    end
  end

  initial begin
    int wait_cyc;
    //                 rst D   sA  sB  Ei  Ed  cnd ms W       F  Ds Db Eb Mb Ws cc h  ps
    step("reset",      0, 1,  15, 15, 1,  15, 1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 0, 2'd0));
    step("idle",       1, 1,  15, 15, 1,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    step("lu_mrmov",   1, 6,  2,  15, 5,  2,  1, 0, 0, mk(1, 1, 0, 1, 0, 0, 0, 0, 2'd0));
    step("lu_clear",   1, 6,  2,  15, 1,  2,  1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    step("lu_popq_B",  1, 6,  15, 3,  11, 3,  1, 0, 0, mk(1, 1, 0, 1, 0, 0, 0, 0, 2'd0));
    step("lu_rnone",   1, 6,  15, 15, 5,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    step("opq_cc",     1, 1,  15, 15, 6,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
    step("mispredict", 1, 9,  15, 15, 7,  15, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 0, 0, 2'd0));
    step("mp_no_load", 1, 1,  15, 15, 1,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    step("jmp_taken",  1, 1,  15, 15, 7,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    step("ret_0",      1, 9,  15, 15, 1,  15, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0));
    step("ret_1",      1, 1,  15, 15, 1,  15, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0));
    step("ret_2",      1, 1,  15, 15, 1,  15, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0));
    step("ret_done",   1, 1,  15, 15, 1,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    step("ret_lu",     1, 9,  2,  15, 5,  2,  1, 0, 0, mk(1, 1, 0, 1, 0, 0, 0, 0, 2'd0));
    step("ret_lu_0",   1, 9,  2,  15, 1,  15, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0));
    step("ret_lu_1",   1, 1,  15, 15, 1,  15, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0));
    step("ret_lu_2",   1, 1,  15, 15, 1,  15, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0));
    step("ret_lu_end", 1, 1,  15, 15, 1,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    step("exc_m",      1, 1,  15, 15, 6,  15, 1, 2, 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0));
    step("drain",      1, 1,  15, 15, 6,  15, 1, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0));
    step("exc_w",      1, 1,  15, 15, 6,  15, 1, 0, 2, mk(0, 0, 0, 0, 1, 1, 0, 0, 2'd0));
    step("halted_0",   1, 1,  15, 15, 6,  15, 1, 0, 0, mk(1, 1, 0, 1, 1, 1, 0, 1, 2'd2));
    step("halted_1",   1, 9,  2,  15, 5,  2,  0, 0, 0, mk(1, 1, 0, 1, 1, 1, 0, 1, 2'd2));
    step("rst_halted", 0, 1,  15, 15, 6,  15, 1, 0, 0, mk(0, 0, 1, 1, 1, 0, 0, 1, 2'd2));
    step("post_rst0",  1, 1,  15, 15, 1,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1, 0);
    step("post_rst1",  1, 1,  15, 15, 1,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1, 1);
    step("post_rst2",  1, 1,  15, 15, 1,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1, 2);
    step("post_rst3",  1, 6,  15, 15, 6,  15, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 2'd0), 1, 3);

    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control and hazard sequencer for the five-stage Y86-64 pipeline (F, D, E, M, W).
- Each cycle it generates stall and bubble controls for the pipeline registers, and the condition-code write enable.
- Tracks in-flight `ret` instructions with a countdown counter.
- Runs an exception state machine (RUN → DRAIN → HALTED) that freezes the processor once a faulting instruction reaches write-back.
- Sits beside the datapath; the decode/write-back stage consumes its E_bubble and W_stall outputs.

Parameters:
- RET_GAP, 2: cycles `ret_cnt` keeps the ret hazard active after `ret` leaves D. Total F-stall cycles per ret = RET_GAP+1.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- D_icode  in  4  icode in D register.
- d_srcA  in  4  decode source A (15 = RNONE).
- d_srcB  in  4  decode source B.
- E_icode  in  4  icode in E register.
- E_dstM  in  4  memory-load destination in E.
- e_Cnd  in  1  branch/cmov condition from execute.
- m_stat  in  2  status out of memory stage.
- W_stat  in  2  status in W register.
- F_stall  out  1  hold F register.
- D_stall  out  1  hold D register.
- D_bubble  out  1  load nop into D.
- E_bubble  out  1  load nop into E.
- M_bubble  out  1  load nop into M.
- W_stall  out  1  hold W register.
- set_cc  out  1  condition-code write enable.
- halted  out  1  processor halted.
- proc_stat  out  2  latched final status.

Behaviour:
- Encodings:
  - stat: AOK=0, HLT=1, ADR=2, INS=3.
  - icode: JXX=7, RET=9, MRMOVQ=5, POPQ=11, OPQ=6.
  - RNONE=15.
- Combinational terms:
  - lu = (E_icode∈{MRMOVQ,POPQ}) & E_dstM≠RNONE & (E_dstM==d_srcA | E_dstM==d_srcB).
  - mp = E_icode==JXX & !e_Cnd.
  - exc_m = m_stat≠AOK.
  - exc_w = W_stat≠AOK.
  - rh = (D_icode==RET | ret_cnt≠0).
- Outputs in state RUN or DRAIN:
  - F_stall = lu | rh.
  - D_stall = lu.
  - D_bubble = mp | (rh & !lu).
  - E_bubble = mp | lu.
  - M_bubble = exc_m | exc_w | (state==DRAIN).
  - W_stall = exc_w.
  - set_cc = E_icode==OPQ & !exc_m & !exc_w & state==RUN.
- D_stall and D_bubble are never both 1. lu has priority over ret.
- ret_cnt (2-bit register):
  - Loads RET_GAP when D_icode==RET & !lu & !mp & state==RUN.
  - Otherwise decrements when nonzero.
  - Cleared on entering DRAIN.
  - A mispredicted jump squashes a RET in D: no load.
- FSM (registered):
  - RUN→DRAIN when exc_m.
  - RUN or DRAIN→HALTED when exc_w; on that edge proc_stat ← W_stat.
  - DRAIN never returns to RUN.
  - HALTED is absorbing until reset.
- HALTED outputs:
  - F_stall=D_stall=W_stall=1.
  - M_bubble=E_bubble=1.
  - D_bubble=0, set_cc=0, halted=1.
- Reset (rst_n low at a clk edge): state=RUN, ret_cnt=0, proc_stat=AOK, halted=0.
- Outputs while rst_n low: all stalls 0, all bubbles 1, set_cc 0.
- Reset mid-DRAIN or mid-HALTED returns to RUN on that edge.
- Latency: hazard outputs are same-cycle combinational; state and proc_stat update on the next clk edge.

Optional Feature:
- Macro `PIPE_CTRL_PERF_EN`.
- When defined, adds four PERF_W-bit outputs, each cleared on reset and wrapping at 2^PERF_W−1 → 0:
  - cyc_cnt: increments every cycle not HALTED.
  - lu_cnt: increments on lu.
  - mp_cnt: increments on mp.
  - ret_cnt_ev: increments when ret_cnt loads.
- Counters freeze in HALTED.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package `y86_pkg`:
  - icode constants.
  - stat constants.
  - RNONE.
  - ctrl_state_t enum {RUN, DRAIN, HALTED}.
- Optional sub-module `hazard_detect`: purely combinational lu/mp/rh terms. The FSM, ret_cnt and counters stay in pipe_ctrl.

Test Plan:
- Load-use:
  - Stimulus: E_icode=5, E_dstM=2, d_srcA=2, D_icode=6.
  - Response: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0 for one cycle; all 0 when E_icode→1.
- Mispredict:
  - Stimulus: E_icode=7, e_Cnd=0, D_icode=9.
  - Response: D_bubble=E_bubble=1, F_stall=1 (rh); next cycle ret_cnt=0 and F_stall=0.
- Ret:
  - Stimulus: D_icode=9 one cycle, then D_icode=1.
  - Response: F_stall=1 and D_bubble=1 for exactly 3 consecutive cycles, then 0.
- Ret during load-use:
  - Stimulus: D_icode=9 with lu active for 1 cycle.
  - Response: D_stall=1, D_bubble=0, no ret_cnt load; ret sequence starts the cycle after.
- Exception:
  - Stimulus: m_stat=2 for 1 cycle, then W_stat=2, E_icode=6.
  - Response: M_bubble=1 and set_cc=0 throughout; state DRAIN then HALTED; halted=1, proc_stat=2, W_stall=1 held.
- Reset from HALTED:
  - Stimulus: rst_n=0 for one edge.
  - Response: halted=0, proc_stat=0, ret_cnt=0; with `PIPE_CTRL_PERF_EN`, cyc_cnt=0 then counts 1,2,3.
